// File: rtl/ga_pkg.sv
// Shared types for the geometric-algebra dispatch queue.
package ga_pkg;

  localparam int unsigned NumBlades  = 8;
  localparam int unsigned CoeffWidth = 16;

  typedef logic [CoeffWidth-1:0] ga_coeff_t;

  // One coefficient per basis blade of a 3D multivector.
  typedef struct packed {
    ga_coeff_t [NumBlades-1:0] blade;
  } ga_multivector_t;

  typedef enum logic [3:0] {
    GaOpAdd     = 4'd0,
    GaOpGeoProd = 4'd1,
    GaOpOuter   = 4'd2,
    GaOpInner   = 4'd3
  } ga_op_e;

  typedef struct packed {
    ga_op_e          op;
    ga_multivector_t a;
    ga_multivector_t b;
  } ga_req_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } ga_dispatch_state_e;

endpackage

// File: rtl/ga_req_fifo.sv
// Power-of-two request FIFO with synchronous flush and occupancy count.
module ga_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AddrW + 1)'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage array; data needs no reset because occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ga_dispatch_queue.sv
// Queues GA requests, issues them one at a time to the execute unit and
// returns tagged responses in accept order, with an optional WAIT timeout.
module ga_dispatch_queue
  import ga_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned TagWidth      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  ga_req_t                 req_i,
  output logic                    exe_valid_o,
  input  logic                    exe_ready_i,
  output ga_req_t                 exe_req_o,
  input  logic                    exe_done_i,
  input  logic                    exe_error_i,
  input  ga_multivector_t         exe_result_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output ga_multivector_t         resp_result_o,
  output logic                    resp_error_o,
  output logic                    resp_timeout_o,
  output logic [TagWidth-1:0]     resp_tag_o,
  input  logic                    flush_i,
  output logic [$clog2(Depth):0]  count_o,
  output logic                    busy_o,
  output logic [31:0]             perf_issued_o,
  output logic [31:0]             perf_timeouts_o
);

  localparam int unsigned ReqW   = $bits(ga_req_t);
  localparam int unsigned EntryW = ReqW + TagWidth;
  localparam int unsigned CntW   = $clog2(Depth) + 1;
  localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerW-1:0] TimerLast =
      TimerW'((TimeoutCycles == 0) ? 32'd0 : TimeoutCycles - 32'd1);

  ga_dispatch_state_e r_state;
  ga_dispatch_state_e w_state_next;
  logic [TagWidth-1:0] r_tag_cnt;
  logic [TagWidth-1:0] r_cur_tag;
  logic [TimerW-1:0]   r_timer;
  ga_multivector_t     r_resp_result;
  logic                r_resp_error;
  logic                r_resp_timeout;
  logic [31:0]         r_perf_issued;
  logic [31:0]         r_perf_timeouts;

  logic                w_push;
  logic                w_exe_fire;
  logic                w_full;
  logic                w_empty;
  logic                w_done_hit;
  logic                w_timeout_hit;
  logic [EntryW-1:0]   w_fifo_wdata;
  logic [EntryW-1:0]   w_fifo_rdata;
  logic [CntW-1:0]     w_count;

  // The tag travels with the request so the response can be labelled later.
  assign w_fifo_wdata = {r_tag_cnt, req_i};

  ga_req_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_fifo_wdata),
    .pop_i   (w_exe_fire),
    .data_o  (w_fifo_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign req_ready_o     = !w_full && !flush_i;
  assign w_push          = req_valid_i && req_ready_o;
  assign exe_valid_o     = (r_state == StIssue);
  assign exe_req_o       = w_fifo_rdata[ReqW-1:0];
  assign w_exe_fire      = exe_valid_o && exe_ready_i;
  assign resp_valid_o    = (r_state == StResp);
  assign resp_result_o   = r_resp_result;
  assign resp_error_o    = r_resp_error;
  assign resp_timeout_o  = r_resp_timeout;
  assign resp_tag_o      = r_cur_tag;
  assign count_o         = w_count;
  assign busy_o          = (r_state != StIdle) || (w_count != '0);
  assign perf_issued_o   = r_perf_issued;
  assign perf_timeouts_o = r_perf_timeouts;

  // A completion on the last timer cycle takes precedence over the timeout.
  assign w_done_hit    = (r_state == StWait) && exe_done_i;
  assign w_timeout_hit = (TimeoutCycles != 0) && (r_state == StWait) && !exe_done_i &&
                         (r_timer == TimerLast);

  // Next-state decode; flush overrides every transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (!w_empty) w_state_next = StIssue;
      StIssue: if (exe_ready_i) w_state_next = StWait;
      StWait:  if (w_done_hit || w_timeout_hit) w_state_next = StResp;
      StResp:  if (resp_ready_i) w_state_next = w_empty ? StIdle : StIssue;
      default: w_state_next = StIdle;
    endcase
    if (flush_i) w_state_next = StIdle;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Tag counter: survives flush, only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_tag_cnt <= '0;
    else if (w_push) r_tag_cnt <= r_tag_cnt + 1'b1;
  end

  // In-flight tag, WAIT timer and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_tag      <= '0;
      r_timer        <= '0;
      r_resp_result  <= '0;
      r_resp_error   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else if (flush_i) begin
      r_timer        <= '0;
      r_resp_result  <= '0;
      r_resp_error   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else if (w_exe_fire) begin
      r_cur_tag <= w_fifo_rdata[EntryW-1 -: TagWidth];
      r_timer   <= '0;
    end else if (w_done_hit) begin
      r_resp_result  <= exe_result_i;
      r_resp_error   <= exe_error_i;
      r_resp_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timer        <= '0;
      r_resp_result  <= '0;
      r_resp_error   <= 1'b1;
      r_resp_timeout <= 1'b1;
    end else if ((r_state == StWait) && (TimeoutCycles != 0)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_issued   <= '0;
      r_perf_timeouts <= '0;
    end else begin
      if (w_exe_fire && (r_perf_issued != '1)) r_perf_issued <= r_perf_issued + 1'b1;
      if (w_timeout_hit && !flush_i && (r_perf_timeouts != '1)) begin
        r_perf_timeouts <= r_perf_timeouts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ga_dispatch_queue.sv
// Scoreboard bench for ga_dispatch_queue with a behavioural execute-unit stub.
module tb_ga_dispatch_queue;
  import ga_pkg::*;

  localparam int unsigned Depth         = 4;
  localparam int unsigned TimeoutCycles = 8;
  localparam int unsigned TagWidth      = 4;
  localparam int unsigned CntW          = $clog2(Depth) + 1;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                req_valid_i;
  logic                req_ready_o;
  ga_req_t             req_i;
  logic                exe_valid_o;
  logic                exe_ready_i;
  ga_req_t             exe_req_o;
  logic                exe_done_i;
  logic                exe_error_i;
  ga_multivector_t     exe_result_i;
  logic                resp_valid_o;
  logic                resp_ready_i;
  ga_multivector_t     resp_result_o;
  logic                resp_error_o;
  logic                resp_timeout_o;
  logic [TagWidth-1:0] resp_tag_o;
  logic                flush_i;
  logic [CntW-1:0]     count_o;
  logic                busy_o;
  logic [31:0]         perf_issued_o;
  logic [31:0]         perf_timeouts_o;

  ga_dispatch_queue #(
    .Depth         (Depth),
    .TimeoutCycles (TimeoutCycles),
    .TagWidth      (TagWidth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_i           (req_i),
    .exe_valid_o     (exe_valid_o),
    .exe_ready_i     (exe_ready_i),
    .exe_req_o       (exe_req_o),
    .exe_done_i      (exe_done_i),
    .exe_error_i     (exe_error_i),
    .exe_result_i    (exe_result_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_result_o   (resp_result_o),
    .resp_error_o    (resp_error_o),
    .resp_timeout_o  (resp_timeout_o),
    .resp_tag_o      (resp_tag_o),
    .flush_i         (flush_i),
    .count_o         (count_o),
    .busy_o          (busy_o),
    .perf_issued_o   (perf_issued_o),
    .perf_timeouts_o (perf_timeouts_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TagWidth-1:0] tag;
    ga_multivector_t     result;
    logic                error;
    logic                timeout;
  } exp_resp_t;

  exp_resp_t           exp_resp_q[$];
  ga_req_t             exp_exe_q[$];
  int                  checks = 0;
  int                  failures = 0;
  int                  stub_lat = 1;
  logic                stub_err = 1'b0;
  logic [TagWidth-1:0] next_tag = '0;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ga_req_t make_req(input ga_op_e op, input logic [7:0] seed);
    ga_req_t r;
    r.op = op;
    for (int k = 0; k < NumBlades; k++) begin
      r.a.blade[k] = {seed, 8'(k)};
      r.b.blade[k] = {8'(3 * k), ~seed};
    end
    return r;
  endfunction

  // Execute-unit stub behaviour: bladewise XOR of the operands.
  function automatic ga_multivector_t stub_result(input ga_req_t r);
    ga_multivector_t m;
    for (int k = 0; k < NumBlades; k++) m.blade[k] = r.a.blade[k] ^ r.b.blade[k];
    return m;
  endfunction

  // Execute stub: done pulses for one cycle, lat cycles into WAIT (lat=0 -> first WAIT cycle).
  ga_req_t stub_req;
  int      stub_lat_now;
  logic    stub_err_now;
  initial begin
    exe_done_i   = 1'b0;
    exe_error_i  = 1'b0;
    exe_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && exe_valid_o && exe_ready_i && !flush_i) begin
        stub_req     = exe_req_o;
        stub_lat_now = stub_lat;
        stub_err_now = stub_err;
        @(posedge clk_i);
        repeat (stub_lat_now) @(posedge clk_i);
        #1;
        exe_done_i   = 1'b1;
        exe_error_i  = stub_err_now;
        exe_result_i = stub_result(stub_req);
        @(posedge clk_i);
        #1;
        exe_done_i   = 1'b0;
        exe_error_i  = 1'b0;
        exe_result_i = '0;
      end
    end
  end

  // Issue monitor: every exe handshake must present the next accepted request.
  ga_req_t mon_req;
  always @(negedge clk_i) begin
    if (rst_ni && exe_valid_o && exe_ready_i && !flush_i) begin
      if (exp_exe_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL exe_unexpected: got issue of op %0h expected no issue", exe_req_o.op);
      end else begin
        mon_req = exp_exe_q.pop_front();
        chk("exe_req", exe_req_o, mon_req);
      end
    end
  end

  // Response monitor.
  exp_resp_t mon_exp;
  always @(negedge clk_i) begin
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      if (exp_resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got response tag %0h expected none", resp_tag_o);
      end else begin
        mon_exp = exp_resp_q.pop_front();
        chk("resp_tag", resp_tag_o, mon_exp.tag);
        chk("resp_result", resp_result_o, mon_exp.result);
        chk("resp_error", resp_error_o, mon_exp.error);
        chk("resp_timeout", resp_timeout_o, mon_exp.timeout);
      end
    end
  end

  // Presents one request until accepted; records the expected issue and response.
  task automatic push_req(input ga_req_t r, input logic err, input logic to);
    exp_resp_t e;
    logic ok;
    ok = 1'b0;
    req_valid_i = 1'b1;
    req_i = r;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_accept: got no accept in 200 cycles expected accept");
    end else begin
      e.tag     = next_tag;
      e.result  = to ? '0 : stub_result(r);
      e.error   = to ? 1'b1 : err;
      e.timeout = to;
      exp_exe_q.push_back(r);
      exp_resp_q.push_back(e);
      next_tag++;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_resp_q.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_outstanding", exp_resp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    exp_resp_q.delete();
    exp_exe_q.delete();
    next_tag = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_exe_valid", exe_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_fields", {resp_result_o, resp_error_o, resp_timeout_o, resp_tag_o}, 0);
    chk("rst_perf", {perf_issued_o, perf_timeouts_o}, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  ga_req_t fill_req;
  exp_resp_t fill_exp;
  logic [299:0] snap;
  int seen;

  initial begin
    req_valid_i  = 1'b0;
    req_i        = '0;
    exe_ready_i  = 1'b0;
    resp_ready_i = 1'b1;
    flush_i      = 1'b0;
    do_reset();

    // Single request: issue two cycles after accept, done in the fourth WAIT cycle.
    exe_ready_i = 1'b1;
    stub_lat = 3;
    push_req(make_req(GaOpAdd, 8'h11), 1'b0, 1'b0);
    @(negedge clk_i);
    chk("issue_latency_n1", exe_valid_o, 0);
    @(negedge clk_i);
    chk("issue_latency_n2", exe_valid_o, 1);
    @(posedge clk_i);
    #1;
    drain(40);

    // Execute error is forwarded without timeout.
    stub_err = 1'b1;
    stub_lat = 0;
    push_req(make_req(GaOpGeoProd, 8'h22), 1'b1, 1'b0);
    drain(40);
    stub_err = 1'b0;

    // Fill with the execute unit stalled: four accepted, fifth refused.
    do_reset();
    exe_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fill_req = make_req(GaOpGeoProd, 8'(8'h30 + i));
      req_valid_i = 1'b1;
      req_i = fill_req;
      @(negedge clk_i);
      chk($sformatf("fill_ready_%0d", i), req_ready_o, (i < 4) ? 1 : 0);
      if (i < 4) begin
        fill_exp.tag = next_tag;
        fill_exp.result = stub_result(fill_req);
        fill_exp.error = 1'b0;
        fill_exp.timeout = 1'b0;
        exp_exe_q.push_back(fill_req);
        exp_resp_q.push_back(fill_exp);
        next_tag++;
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("full_count", count_o, 4);
    chk("full_busy", busy_o, 1);
    @(posedge clk_i);
    #1;
    exe_ready_i = 1'b1;
    stub_lat = 1;
    drain(100);
    @(negedge clk_i);
    chk("fill_perf_issued", perf_issued_o, 4);
    @(posedge clk_i);
    #1;

    // Timeout: response in the 9th cycle after issue, late done ignored.
    stub_lat = 12;
    push_req(make_req(GaOpOuter, 8'h44), 1'b0, 1'b1);
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        seen = i;
        break;
      end
    end
    chk("timeout_latency", seen, 11);
    @(posedge clk_i);
    #1;
    drain(10);
    wait_cycles(10);
    @(negedge clk_i);
    chk("timeout_perf", perf_timeouts_o, 1);
    chk("timeout_idle", {busy_o, resp_valid_o}, 0);
    @(posedge clk_i);
    #1;

    // Done on the last timer cycle wins over the timeout.
    stub_lat = 7;
    push_req(make_req(GaOpInner, 8'h55), 1'b0, 1'b0);
    drain(40);
    wait_cycles(3);
    @(negedge clk_i);
    chk("race_perf_timeouts", perf_timeouts_o, 1);
    @(posedge clk_i);
    #1;

    // Back-pressured response holds every field.
    resp_ready_i = 1'b0;
    stub_lat = 1;
    push_req(make_req(GaOpAdd, 8'h66), 1'b0, 1'b0);
    seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        seen = i;
        break;
      end
    end
    chk("stall_resp_seen", seen != 0, 1);
    snap = {resp_result_o, resp_error_o, resp_timeout_o, resp_tag_o};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_valid", resp_valid_o, 1);
      chk("stall_fields", {resp_result_o, resp_error_o, resp_timeout_o, resp_tag_o}, snap);
    end
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b1;
    drain(10);

    // Flush in WAIT with two queued; done one cycle after flush is ignored.
    stub_lat = 3;
    push_req(make_req(GaOpAdd, 8'h77), 1'b0, 1'b0);
    push_req(make_req(GaOpAdd, 8'h78), 1'b0, 1'b0);
    push_req(make_req(GaOpAdd, 8'h79), 1'b0, 1'b0);
    @(negedge clk_i);
    chk("flush_pre_count", count_o, 2);
    chk("flush_pre_wait", {exe_valid_o, resp_valid_o, busy_o}, 3'b001);
    wait_cycles(2);
    flush_i = 1'b1;
    exp_resp_q.delete();
    exp_exe_q.delete();
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_count", count_o, 0);
    chk("flush_idle", {exe_valid_o, resp_valid_o, busy_o}, 0);
    wait_cycles(6);
    @(negedge clk_i);
    chk("flush_no_resp", {resp_valid_o, busy_o}, 0);
    @(posedge clk_i);
    #1;
    stub_lat = 1;
    push_req(make_req(GaOpOuter, 8'h7a), 1'b0, 1'b0);
    drain(40);

    // Reset mid-flight abandons the request without a response.
    stub_lat = 20;
    push_req(make_req(GaOpInner, 8'h90), 1'b0, 1'b0);
    wait_cycles(4);
    do_reset();
    wait_cycles(25);
    @(negedge clk_i);
    chk("rst_mid_idle", {resp_valid_o, busy_o}, 0);
    @(posedge clk_i);
    #1;

    // Seventeen accepts wrap the 4-bit tag back to 0.
    stub_lat = 0;
    for (int i = 0; i < 17; i++) push_req(make_req(GaOpAdd, 8'(8'h80 + i)), 1'b0, 1'b0);
    drain(300);
    @(negedge clk_i);
    chk("wrap_perf_issued", perf_issued_o, 17);
    chk("wrap_idle", {busy_o, count_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
